// File: rtl/fmul_float_norm_round.sv
// fmul back end: normalize, round and pack a raw 48-bit product to binary32.
// Define FMUL_NORM_ROUND_NEAREST_EN for round-to-nearest-even, else truncate.
module fmul_float_norm_round (
  input  logic        iCLOCK,
  input  logic        iRESET,
  input  logic        iRESET_SYNC,
  input  logic        iDATA_REQ,
  output logic        oDATA_BUSY,
  input  logic        iDATA_SIGN,
  input  logic [9:0]  iDATA_EXP,
  input  logic [47:0] iDATA_FRACT,
  input  logic        iDATA_EXCEPT_EXP_A0,
  input  logic        iDATA_EXCEPT_EXP_B0,
  input  logic        iDATA_EXCEPT_EXP_A1,
  input  logic        iDATA_EXCEPT_EXP_B1,
  input  logic        iDATA_EXCEPT_FRACT_A0,
  input  logic        iDATA_EXCEPT_FRACT_B0,
  output logic        oDATA_VALID,
  input  logic        iDATA_BUSY,
  output logic [31:0] oDATA_RESULT,
  output logic        oDATA_FLAG_INVALID,
  output logic        oDATA_FLAG_OVERFLOW,
  output logic        oDATA_FLAG_UNDERFLOW,
  output logic        oDATA_FLAG_INEXACT
);

  typedef struct packed {
    logic               valid;
    logic               spec;
    logic [31:0]        spec_res;
    logic               invalid;
    logic               sign;
    logic signed [10:0] exp;
    logic [22:0]        mant;
    logic               guard;
    logic               sticky;
  } norm_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic        invalid;
    logic        overflow;
    logic        underflow;
    logic        inexact;
  } pack_t;

  norm_t s1_d, s1_q;
  pack_t s2_d, s2_q;

  logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic signed [10:0] exp_in;

  assign oDATA_BUSY = iDATA_BUSY;

  assign nan_a  = iDATA_EXCEPT_EXP_A1 & ~iDATA_EXCEPT_FRACT_A0;
  assign nan_b  = iDATA_EXCEPT_EXP_B1 & ~iDATA_EXCEPT_FRACT_B0;
  assign inf_a  = iDATA_EXCEPT_EXP_A1 &  iDATA_EXCEPT_FRACT_A0;
  assign inf_b  = iDATA_EXCEPT_EXP_B1 &  iDATA_EXCEPT_FRACT_B0;
  assign zero_a = iDATA_EXCEPT_EXP_A0;
  assign zero_b = iDATA_EXCEPT_EXP_B0;

  assign exp_in = {iDATA_EXP[9], iDATA_EXP};

  always_comb begin
    s1_d          = '0;
    s1_d.valid    = iDATA_REQ;
    s1_d.sign     = iDATA_SIGN;
    if (nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a)) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_res = 32'h7FC0_0000;
      s1_d.invalid  = 1'b1;
    end else if (inf_a | inf_b) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_res = {iDATA_SIGN, 8'hFF, 23'h0};
    end else if (zero_a | zero_b) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_res = {iDATA_SIGN, 31'h0};
    end else if (iDATA_FRACT[47]) begin
      s1_d.exp    = exp_in + 11'sd1;
      s1_d.mant   = iDATA_FRACT[46:24];
      s1_d.guard  = iDATA_FRACT[23];
      s1_d.sticky = |iDATA_FRACT[22:0];
    end else begin
      s1_d.exp    = exp_in;
      s1_d.mant   = iDATA_FRACT[45:23];
      s1_d.guard  = iDATA_FRACT[22];
      s1_d.sticky = |iDATA_FRACT[21:0];
    end
  end

  logic               inc;
  logic [24:0]        sum;
  logic               carry;
  logic [22:0]        mant_r;
  logic signed [10:0] exp_r;
  logic [31:0]        ovf_res;

`ifdef FMUL_NORM_ROUND_NEAREST_EN
  assign inc     = s1_q.guard & (s1_q.sticky | s1_q.mant[0]);
  assign ovf_res = {s1_q.sign, 8'hFF, 23'h0};
`else
  assign inc     = 1'b0;
  assign ovf_res = {s1_q.sign, 8'hFE, 23'h7F_FFFF};
`endif

  assign sum    = {2'b01, s1_q.mant} + {24'h0, inc};
  assign carry  = sum[24];
  assign mant_r = carry ? 23'h0 : sum[22:0];
  assign exp_r  = s1_q.exp + {10'h0, carry};

  always_comb begin
    s2_d       = '0;
    s2_d.valid = s1_q.valid;
    if (s1_q.spec) begin
      s2_d.result  = s1_q.spec_res;
      s2_d.invalid = s1_q.invalid;
    end else if (exp_r >= 11'sd255) begin
      s2_d.result   = ovf_res;
      s2_d.overflow = 1'b1;
      s2_d.inexact  = 1'b1;
    end else if (exp_r <= 11'sd0) begin
      s2_d.result    = {s1_q.sign, 31'h0};
      s2_d.underflow = 1'b1;
      s2_d.inexact   = 1'b1;
    end else begin
      s2_d.result  = {s1_q.sign, exp_r[7:0], mant_r};
      s2_d.inexact = s1_q.guard | s1_q.sticky;
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      s1_q <= '0;
      s2_q <= '0;
    end else if (iRESET_SYNC) begin
      s1_q <= '0;
      s2_q <= '0;
    end else if (!iDATA_BUSY) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign oDATA_VALID          = s2_q.valid;
  assign oDATA_RESULT         = s2_q.result;
  assign oDATA_FLAG_INVALID   = s2_q.invalid;
  assign oDATA_FLAG_OVERFLOW  = s2_q.overflow;
  assign oDATA_FLAG_UNDERFLOW = s2_q.underflow;
  assign oDATA_FLAG_INEXACT   = s2_q.inexact;

endmodule

// File: tb/tb_fmul_float_norm_round.sv
// Directed bench for fmul_float_norm_round.
// Expected values are hand-derived per rounding mode.
module tb_fmul_float_norm_round;

  logic        iCLOCK = 1'b0;
  logic        iRESET = 1'b1;
  logic        iRESET_SYNC = 1'b0;
  logic        iDATA_REQ = 1'b0;
  logic        oDATA_BUSY;
  logic        iDATA_SIGN = 1'b0;
  logic [9:0]  iDATA_EXP = '0;
  logic [47:0] iDATA_FRACT = '0;
  logic        a0 = 0, b0 = 0, a1 = 0, b1 = 0, fa0 = 0, fb0 = 0;
  logic        oDATA_VALID;
  logic        iDATA_BUSY = 1'b0;
  logic [31:0] oDATA_RESULT;
  logic        f_inv, f_ovf, f_unf, f_inx;

  int n_cmp = 0;
  int n_bad = 0;

  fmul_float_norm_round dut (
    .iCLOCK(iCLOCK), .iRESET(iRESET), .iRESET_SYNC(iRESET_SYNC),
    .iDATA_REQ(iDATA_REQ), .oDATA_BUSY(oDATA_BUSY),
    .iDATA_SIGN(iDATA_SIGN), .iDATA_EXP(iDATA_EXP),
    .iDATA_FRACT(iDATA_FRACT),
    .iDATA_EXCEPT_EXP_A0(a0), .iDATA_EXCEPT_EXP_B0(b0),
    .iDATA_EXCEPT_EXP_A1(a1), .iDATA_EXCEPT_EXP_B1(b1),
    .iDATA_EXCEPT_FRACT_A0(fa0), .iDATA_EXCEPT_FRACT_B0(fb0),
    .oDATA_VALID(oDATA_VALID), .iDATA_BUSY(iDATA_BUSY),
    .oDATA_RESULT(oDATA_RESULT),
    .oDATA_FLAG_INVALID(f_inv), .oDATA_FLAG_OVERFLOW(f_ovf),
    .oDATA_FLAG_UNDERFLOW(f_unf), .oDATA_FLAG_INEXACT(f_inx)
  );

  always #5 iCLOCK = ~iCLOCK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [9:0] e,
                       input logic [47:0] f);
    iDATA_REQ   = 1'b1;
    iDATA_SIGN  = s;
    iDATA_EXP   = e;
    iDATA_FRACT = f;
  endtask

  task automatic flags(input logic xa0, input logic xa1, input logic xfa0,
                       input logic xb0, input logic xb1, input logic xfb0);
    a0 = xa0; a1 = xa1; fa0 = xfa0;
    b0 = xb0; b1 = xb1; fb0 = xfb0;
  endtask

  // Single item: present, drop REQ, then check two edges after presenting.
  task automatic one(input string tag, input logic s, input logic [9:0] e,
                     input logic [47:0] f, input logic [31:0] res,
                     input logic [3:0] fl);
    @(negedge iCLOCK);
    drive(s, e, f);
    @(negedge iCLOCK);
    iDATA_REQ = 1'b0;
    @(negedge iCLOCK);
    chk({tag, ".valid"}, {31'h0, oDATA_VALID}, 32'h1);
    chk({tag, ".res"}, oDATA_RESULT, res);
    chk({tag, ".flags"}, {28'h0, f_inv, f_ovf, f_unf, f_inx}, {28'h0, fl});
    flags(0, 0, 0, 0, 0, 0);
  endtask

  logic [31:0] r_tie_up, r_carry, r_ovf, r_ovf_pos;

  initial begin
`ifdef FMUL_NORM_ROUND_NEAREST_EN
    r_tie_up  = 32'h3F80_0002;
    r_carry   = 32'h4000_0000;
    r_ovf     = 32'hFF80_0000;
    r_ovf_pos = 32'h7F80_0000;
`else
    r_tie_up  = 32'h3F80_0001;
    r_carry   = 32'h3FFF_FFFF;
    r_ovf     = 32'hFF7F_FFFF;
    r_ovf_pos = 32'h7F7F_FFFF;
`endif
    #2;
    chk("rst.valid", {31'h0, oDATA_VALID}, 32'h0);
    chk("rst.res", oDATA_RESULT, 32'h0);
    chk("rst.flags", {28'h0, f_inv, f_ovf, f_unf, f_inx}, 32'h0);
    @(negedge iCLOCK);
    iRESET = 1'b0;

    one("mul1p5", 0, 10'h07F, 48'h9000_0000_0000, 32'h4010_0000, 4'b0000);
    one("tie_even", 0, 10'h07F, 48'h4000_0040_0000, 32'h3F80_0000, 4'b0001);
    one("tie_up", 0, 10'h07F, 48'h4000_00C0_0000, r_tie_up, 4'b0001);
    one("carry", 0, 10'h07F, 48'h7FFF_FFC0_0000, r_carry, 4'b0001);
    one("ovf", 1, 10'h17F, 48'h8000_0000_0000, r_ovf, 4'b0101);
    one("ovf255", 0, 10'h0FE, 48'h8000_0000_0000, r_ovf_pos, 4'b0101);
    one("max254", 0, 10'h0FE, 48'h4000_0000_0000, 32'h7F00_0000, 4'b0000);
    one("min1", 0, 10'h001, 48'h4000_0000_0000, 32'h0080_0000, 4'b0000);
    one("unf0", 0, 10'h000, 48'h4000_0000_0000, 32'h0000_0000, 4'b0011);
    one("unf", 1, 10'h381, 48'h4000_0000_0000, 32'h8000_0000, 4'b0011);

    flags(0, 1, 1, 1, 0, 0);
    one("inf_x_zero", 0, 10'h07F, 48'h4000_0000_0000, 32'h7FC0_0000, 4'b1000);
    flags(0, 1, 1, 0, 0, 0);
    one("inf", 1, 10'h07F, 48'h4000_0000_0000, 32'hFF80_0000, 4'b0000);
    flags(0, 0, 0, 0, 1, 0);
    one("nan_b", 0, 10'h07F, 48'h4000_0000_0000, 32'h7FC0_0000, 4'b1000);
    flags(1, 0, 0, 0, 0, 0);
    one("zero", 1, 10'h07F, 48'h4000_0000_0000, 32'h8000_0000, 4'b0000);

    // Back-to-back stream with a 3-cycle stall in the middle.
    @(negedge iCLOCK);
    drive(0, 10'h07F, 48'h8000_0000_0000);
    @(negedge iCLOCK);
    drive(0, 10'h080, 48'h8000_0000_0000);
    @(negedge iCLOCK);
    chk("bp.r0", oDATA_RESULT, 32'h4000_0000);
    chk("bp.v0", {31'h0, oDATA_VALID}, 32'h1);
    drive(0, 10'h081, 48'h8000_0000_0000);
    iDATA_BUSY = 1'b1;
    #1;
    chk("bp.busy", {31'h0, oDATA_BUSY}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge iCLOCK);
      chk("bp.hold", oDATA_RESULT, 32'h4000_0000);
      chk("bp.hold_v", {31'h0, oDATA_VALID}, 32'h1);
    end
    iDATA_BUSY = 1'b0;
    #1;
    chk("bp.unbusy", {31'h0, oDATA_BUSY}, 32'h0);
    @(negedge iCLOCK);
    chk("bp.r1", oDATA_RESULT, 32'h4080_0000);
    drive(0, 10'h082, 48'h8000_0000_0000);
    @(negedge iCLOCK);
    chk("bp.r2", oDATA_RESULT, 32'h4100_0000);
    iDATA_REQ = 1'b0;
    @(negedge iCLOCK);
    chk("bp.r3", oDATA_RESULT, 32'h4180_0000);
    chk("bp.v3", {31'h0, oDATA_VALID}, 32'h1);
    @(negedge iCLOCK);
    chk("bp.drain", {31'h0, oDATA_VALID}, 32'h0);

    // Asynchronous reset mid-stream.
    drive(0, 10'h07F, 48'h9000_0000_0000);
    @(negedge iCLOCK);
    drive(0, 10'h080, 48'h9000_0000_0000);
    @(negedge iCLOCK);
    chk("ar.pre", {31'h0, oDATA_VALID}, 32'h1);
    iRESET = 1'b1;
    #1;
    chk("ar.valid", {31'h0, oDATA_VALID}, 32'h0);
    chk("ar.res", oDATA_RESULT, 32'h0);
    iDATA_REQ = 1'b0;
    @(negedge iCLOCK);
    iRESET = 1'b0;
    @(negedge iCLOCK);
    chk("ar.flushed", {31'h0, oDATA_VALID}, 32'h0);

    // Synchronous clear wins over busy.
    drive(0, 10'h07F, 48'h9000_0000_0000);
    @(negedge iCLOCK);
    iDATA_REQ = 1'b0;
    @(negedge iCLOCK);
    chk("sr.pre", oDATA_RESULT, 32'h4010_0000);
    iRESET_SYNC = 1'b1;
    iDATA_BUSY  = 1'b1;
    @(negedge iCLOCK);
    chk("sr.valid", {31'h0, oDATA_VALID}, 32'h0);
    chk("sr.res", oDATA_RESULT, 32'h0);
    iRESET_SYNC = 1'b0;
    iDATA_BUSY  = 1'b0;
    @(negedge iCLOCK);
    chk("sr.after", {31'h0, oDATA_VALID}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fmul_float_norm_round.md
# fmul_float_norm_round

- Back end of the single-precision multiplier: consumes the raw product stream of the `fmul` calculation stage (sign, unnormalized exponent, 48-bit significand product, operand class flags).
- Produces a packed IEEE-754 binary32 result plus exception flags.
- Two-stage pipeline (normalize, then round/pack) using the same REQ/BUSY/VALID handshake as the calculation stage, so the two blocks chain directly.

## Interface
No parameters.
- iCLOCK  in  1  clock, all state on rising edge
- iRESET  in  1  asynchronous, active-high reset
- iRESET_SYNC  in  1  synchronous clear, same effect as iRESET
- iDATA_REQ  in  1  input item valid
- oDATA_BUSY  out  1  input stall; combinational copy of iDATA_BUSY
- iDATA_SIGN  in  1  product sign
- iDATA_EXP  in  10  signed two's-complement exponent eA+eB-127 (range -127..383)
- iDATA_FRACT  in  48  24x24 significand product, hidden bits included
- iDATA_EXCEPT_EXP_A0 / _B0  in  1  operand exponent all zero
- iDATA_EXCEPT_EXP_A1 / _B1  in  1  operand exponent all ones
- iDATA_EXCEPT_FRACT_A0 / _B0  in  1  operand fraction all zero
- oDATA_VALID  out  1  result valid
- iDATA_BUSY  in  1  downstream stall
- oDATA_RESULT  out  32  packed binary32
- oDATA_FLAG_INVALID / _OVERFLOW / _UNDERFLOW / _INEXACT  out  1  exception flags

## Operation
**Operand class (stage 1, per operand X):**
- NaN = EXP_X1 & !FRACT_X0.
- Inf = EXP_X1 & FRACT_X0.
- Zero = EXP_X0. Denormal inputs are flushed to zero.

**Special-case priority (stage 1):**
1. Either operand NaN, or Inf x Zero -> 0x7FC00000, INVALID=1.
2. Either operand Inf -> {sign, 8'hFF, 23'h0}.
3. Either operand Zero -> {sign, 31'h0}.
4. Otherwise take the normal path.

**Stage 1 normalize (normal path):**
- Internal exponent is 11-bit signed; no wrap is permitted.
- FRACT[47]=1: mant=FRACT[46:24], guard=FRACT[23], sticky=|FRACT[22:0], exp=EXP+1.
- Else: mant=FRACT[45:23], guard=FRACT[22], sticky=|FRACT[21:0], exp=EXP.

**Stage 2 round/pack:**
- inc per rounding mode (see Configuration). Compute {carry,mant'} = {1,mant}+inc; on carry, exp+=1 and mant'=0.
- exp >= 255 -> overflow: OVERFLOW=1, INEXACT=1, result per rounding mode.
- exp <= 0 -> flush to signed zero: UNDERFLOW=1, INEXACT=1.
- Otherwise {sign, exp[7:0], mant'}, INEXACT = guard|sticky.
- Special-case results carry only INVALID; all other flags 0.

## Timing
- Item accepted on a rising edge when iDATA_REQ=1 and iDATA_BUSY=0.
- Latency is exactly 2 cycles from acceptance to oDATA_VALID.
- Throughput is 1 item per cycle.
- Both stage registers (valid + data) load only when iDATA_BUSY=0. While busy, every register holds and the outputs stay stable.
- Stage valid loads iDATA_REQ; bubbles propagate as VALID=0.
- iRESET (any time, including mid-stream) or iRESET_SYNC clears both stages. Reset value of every output is 0, including oDATA_VALID and oDATA_RESULT=0x00000000. In-flight items are discarded.
- iRESET_SYNC takes priority over iDATA_BUSY.

## Configuration
`FMUL_NORM_ROUND_NEAREST_EN`:
- **Defined:** round-to-nearest-even. inc = guard & (sticky | mant[0]). Overflow result is {sign, 8'hFF, 0} (Inf).
- **Undefined:** round toward zero. inc=0. Overflow result is {sign, 8'hFE, 23'h7FFFFF} (max finite). INEXACT computation is unchanged.

## Test plan
1. 1.5x1.5: SIGN=0, EXP=0x07F, FRACT=0x900000000000 -> 2 cycles later RESULT=0x40100000, all flags 0.
2. Tie/round-up, EXP=0x07F:
   - FRACT=0x400000400000 -> 0x3F800000, INEXACT=1 in both modes.
   - FRACT=0x400000C00000 -> 0x3F800002 (macro defined) / 0x3F800001 (undefined), INEXACT=1.
3. Overflow: SIGN=1, EXP=0x17F, FRACT=0x800000000000 -> 0xFF800000 (defined) / 0xFF7FFFFF (undefined), OVERFLOW=1, INEXACT=1.
4. Underflow: EXP=0x381 (-127), FRACT=0x400000000000, SIGN=1 -> 0x80000000, UNDERFLOW=1.
5. Specials:
   - EXP_A1=1, FRACT_A0=1, EXP_B0=1 -> 0x7FC00000, INVALID=1.
   - EXP_A1=1, FRACT_A0=1, SIGN=1, B normal -> 0xFF800000, INVALID=0.
6. Back-to-back items, backpressure and reset:
   - Issue 4 items back-to-back. Hold iDATA_BUSY=1 for 3 cycles mid-stream -> oDATA_BUSY=1, outputs frozen, all 4 results delivered in order with no loss or duplication.
   - Assert iRESET mid-stream -> oDATA_VALID=0 immediately.
